// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter and its watchdog.
package mem_port_arbiter_pkg;

   localparam int XLEN_DEFAULT = 32;

   // Size/sign code used for every instruction-cache refill (full word).
   localparam logic [2:0] F3_WORD = 3'b010;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_e;

   typedef enum logic {
      GNT_IC = 1'b0,
      GNT_DM = 1'b1
   } arb_gnt_e;

   // Picks the next owner. On a tie the requester that was not served
   // last wins, so two continuously active requesters strictly alternate.
   function automatic arb_gnt_e pick_grant(
      input logic     ic_want,
      input logic     dm_want,
      input arb_gnt_e last
   );
      arb_gnt_e g;
      if (ic_want && dm_want) begin
         g = (last == GNT_DM) ? GNT_IC : GNT_DM;
      end else if (ic_want) begin
         g = GNT_IC;
      end else begin
         g = GNT_DM;
      end
      return g;
   endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Transaction watchdog for a bus master: counts cycles while enabled and
// flags expiry on the cycle the count reaches TIMEOUT-1. TIMEOUT=0 disables
// it entirely. Kept generic so other bus masters can reuse it.
module mem_arb_watchdog #(
   parameter int TIMEOUT = 1024,
   parameter int CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   generate
      if (TIMEOUT > 0) begin : g_on
         localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

         logic [CW-1:0] count;

         // Count waiting cycles; saturate at the limit so expiry stays asserted.
         always_ff @(posedge i_clk) begin
            if (!i_rst || i_clear) begin
               count <= '0;
            end else if (i_enable && (count != LIMIT)) begin
               count <= count + CW'(1);
            end
         end

         assign o_expired = (count == LIMIT);
      end else begin : g_off
         logic unused_ctrl;

         assign unused_ctrl = ^{i_clk, i_rst, i_clear, i_enable};
         assign o_expired   = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between the I-cache refill requester and
// the data-memory requester of a hart. Transactions are serialised, ties are
// broken round-robin, and a watchdog turns a missing ack into an error
// completion.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ARB_IDLE | no transaction; sample requests and grant one
//   ARB_BUSY | o_mem_req held with latched payload, waiting for ack/timeout
//   ARB_RESP | one-cycle ready pulse to the served requester; no sampling
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int XLEN    = XLEN_DEFAULT,
   parameter int TIMEOUT = 1024
) (
   input  logic            i_clk,
   input  logic            i_rst,

   input  logic            i_ic_req,
   input  logic [XLEN-1:0] i_ic_addr,
   output logic [XLEN-1:0] o_ic_rdata,
   output logic            o_ic_ready,
   output logic            o_ic_err,

   input  logic            i_dm_rd,
   input  logic            i_dm_wr,
   input  logic [XLEN-1:0] i_dm_addr,
   input  logic [XLEN-1:0] i_dm_wd,
   input  logic [2:0]      i_dm_f3,
   output logic [XLEN-1:0] o_dm_rdata,
   output logic            o_dm_ready,
   output logic            o_dm_err,

   output logic            o_mem_req,
   output logic            o_mem_we,
   output logic [XLEN-1:0] o_mem_addr,
   output logic [XLEN-1:0] o_mem_wd,
   output logic [2:0]      o_mem_f3,
   input  logic            i_mem_ack,
   input  logic [XLEN-1:0] i_mem_rdata
);

   localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   arb_state_e state;
   arb_gnt_e   grant;
   arb_gnt_e   last_grant;
   arb_gnt_e   next_grant;

   logic ic_want;
   logic dm_want;
   logic wd_clear;
   logic wd_enable;
   logic wd_expired;
   logic txn_done;

   assign ic_want    = i_ic_req;
   assign dm_want    = i_dm_rd | i_dm_wr;
   assign next_grant = pick_grant(ic_want, dm_want, last_grant);

   // Watchdog only runs while a transaction is outstanding and unacknowledged.
   assign wd_clear  = (state != ARB_BUSY);
   assign wd_enable = (state == ARB_BUSY) && !i_mem_ack;

   // An ack in the expiry cycle takes priority over the timeout.
   assign txn_done = i_mem_ack || wd_expired;

   mem_arb_watchdog #(
      .TIMEOUT (TIMEOUT),
      .CW      (TO_W)
   ) u_watchdog (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clear   (wd_clear),
      .i_enable  (wd_enable),
      .o_expired (wd_expired)
   );

   // Arbitration FSM with all outputs registered.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state      <= ARB_IDLE;
         grant      <= GNT_IC;
         last_grant <= GNT_DM;
         o_mem_req  <= 1'b0;
         o_mem_we   <= 1'b0;
         o_mem_addr <= '0;
         o_mem_wd   <= '0;
         o_mem_f3   <= '0;
         o_ic_rdata <= '0;
         o_ic_ready <= 1'b0;
         o_ic_err   <= 1'b0;
         o_dm_rdata <= '0;
         o_dm_ready <= 1'b0;
         o_dm_err   <= 1'b0;
      end else begin
         o_ic_ready <= 1'b0;
         o_dm_ready <= 1'b0;

         case (state)
            ARB_IDLE: begin
               if (ic_want || dm_want) begin
                  grant      <= next_grant;
                  last_grant <= next_grant;
                  o_mem_req  <= 1'b1;
                  state      <= ARB_BUSY;
                  if (next_grant == GNT_IC) begin
                     o_mem_we   <= 1'b0;
                     o_mem_addr <= i_ic_addr;
                     o_mem_wd   <= '0;
                     o_mem_f3   <= F3_WORD;
                  end else begin
                     // A write wins if the DM port raises both strobes.
                     o_mem_we   <= i_dm_wr;
                     o_mem_addr <= i_dm_addr;
                     o_mem_wd   <= i_dm_wd;
                     o_mem_f3   <= i_dm_f3;
                  end
               end
            end

            ARB_BUSY: begin
               if (txn_done) begin
                  o_mem_req <= 1'b0;
                  state     <= ARB_RESP;
                  if (grant == GNT_IC) begin
                     o_ic_rdata <= i_mem_ack ? i_mem_rdata : '0;
                     o_ic_err   <= !i_mem_ack;
                     o_ic_ready <= 1'b1;
                  end else begin
                     // Writes return no data.
                     o_dm_rdata <= (i_mem_ack && !o_mem_we) ? i_mem_rdata : '0;
                     o_dm_err   <= !i_mem_ack;
                     o_dm_ready <= 1'b1;
                  end
               end
            end

            ARB_RESP: begin
               state <= ARB_IDLE;
            end

            default: begin
               state     <= ARB_IDLE;
               o_mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with a transaction-level
// reference model compared against the outputs on every falling edge.
module tb_mem_port_arbiter;

   localparam int XLEN    = 32;
   localparam int TIMEOUT = 8;

   logic            i_clk = 1'b0;
   logic            i_rst = 1'b0;
   logic            i_ic_req = 1'b0;
   logic [XLEN-1:0] i_ic_addr = '0;
   logic [XLEN-1:0] o_ic_rdata;
   logic            o_ic_ready;
   logic            o_ic_err;
   logic            i_dm_rd = 1'b0;
   logic            i_dm_wr = 1'b0;
   logic [XLEN-1:0] i_dm_addr = '0;
   logic [XLEN-1:0] i_dm_wd = '0;
   logic [2:0]      i_dm_f3 = '0;
   logic [XLEN-1:0] o_dm_rdata;
   logic            o_dm_ready;
   logic            o_dm_err;
   logic            o_mem_req;
   logic            o_mem_we;
   logic [XLEN-1:0] o_mem_addr;
   logic [XLEN-1:0] o_mem_wd;
   logic [2:0]      o_mem_f3;
   logic            i_mem_ack = 1'b0;
   logic [XLEN-1:0] i_mem_rdata = '0;

   int n_checks = 0;
   int n_fail   = 0;

   mem_port_arbiter #(
      .XLEN    (XLEN),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_ic_req    (i_ic_req),
      .i_ic_addr   (i_ic_addr),
      .o_ic_rdata  (o_ic_rdata),
      .o_ic_ready  (o_ic_ready),
      .o_ic_err    (o_ic_err),
      .i_dm_rd     (i_dm_rd),
      .i_dm_wr     (i_dm_wr),
      .i_dm_addr   (i_dm_addr),
      .i_dm_wd     (i_dm_wd),
      .i_dm_f3     (i_dm_f3),
      .o_dm_rdata  (o_dm_rdata),
      .o_dm_ready  (o_dm_ready),
      .o_dm_err    (o_dm_err),
      .o_mem_req   (o_mem_req),
      .o_mem_we    (o_mem_we),
      .o_mem_addr  (o_mem_addr),
      .o_mem_wd    (o_mem_wd),
      .o_mem_f3    (o_mem_f3),
      .i_mem_ack   (i_mem_ack),
      .i_mem_rdata (i_mem_rdata)
   );

   initial begin
      forever #5 i_clk = ~i_clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one outstanding transaction at a time, owner 0 = IC,
   // 1 = DM; a finished transaction is answered for exactly one cycle.
   bit              model_ok = 0;
   bit              busy = 0;
   bit              answering = 0;
   int              owner = 0;
   int              last_owner = 1;
   int              waited = 0;
   logic            e_req = 0, e_we = 0;
   logic [XLEN-1:0] e_addr = '0, e_wd = '0;
   logic [2:0]      e_f3 = '0;
   logic [XLEN-1:0] e_ic_rdata = '0, e_dm_rdata = '0;
   logic            e_ic_err = 0, e_dm_err = 0, e_ic_ready = 0, e_dm_ready = 0;

   initial begin
      forever begin
         @(posedge i_clk);
         e_ic_ready = 0;
         e_dm_ready = 0;
         if (!i_rst) begin
            busy = 0; answering = 0; last_owner = 1;
            e_req = 0; e_we = 0; e_addr = '0; e_wd = '0; e_f3 = '0;
            e_ic_rdata = '0; e_ic_err = 0; e_dm_rdata = '0; e_dm_err = 0;
         end else if (answering) begin
            answering = 0;
         end else if (busy) begin
            if (i_mem_ack || (TIMEOUT > 0 && waited == TIMEOUT - 1)) begin
               busy = 0;
               answering = 1;
               e_req = 0;
               if (owner == 0) begin
                  e_ic_ready = 1;
                  e_ic_err   = !i_mem_ack;
                  e_ic_rdata = i_mem_ack ? i_mem_rdata : '0;
               end else begin
                  e_dm_ready = 1;
                  e_dm_err   = !i_mem_ack;
                  e_dm_rdata = (i_mem_ack && !e_we) ? i_mem_rdata : '0;
               end
            end else begin
               waited++;
            end
         end else if (i_ic_req || i_dm_rd || i_dm_wr) begin
            if (i_ic_req && (i_dm_rd || i_dm_wr)) owner = 1 - last_owner;
            else owner = i_ic_req ? 0 : 1;
            last_owner = owner;
            busy = 1;
            waited = 0;
            e_req = 1;
            if (owner == 0) begin
               e_we = 0; e_addr = i_ic_addr; e_f3 = 3'b010;
            end else begin
               e_we = i_dm_wr; e_addr = i_dm_addr; e_wd = i_dm_wd; e_f3 = i_dm_f3;
            end
         end
         model_ok = 1;
      end
   end

   // Per-cycle comparison against the model, away from the rising edge.
   initial begin
      forever begin
         @(negedge i_clk);
         if (model_ok) begin
            chk("mem_req", o_mem_req, e_req);
            chk("ic_ready", o_ic_ready, e_ic_ready);
            chk("dm_ready", o_dm_ready, e_dm_ready);
            if (e_req) begin
               chk("mem_addr", o_mem_addr, e_addr);
               chk("mem_we", o_mem_we, e_we);
               chk("mem_f3", o_mem_f3, e_f3);
               if (e_we) chk("mem_wd", o_mem_wd, e_wd);
            end
            if (e_ic_ready) begin
               chk("ic_rdata", o_ic_rdata, e_ic_rdata);
               chk("ic_err", o_ic_err, e_ic_err);
            end
            if (e_dm_ready) begin
               chk("dm_rdata", o_dm_rdata, e_dm_rdata);
               chk("dm_err", o_dm_err, e_dm_err);
            end
         end
      end
   end

   task automatic wait_req(input string tag);
      int k = 0;
      while (o_mem_req !== 1'b1 && k < 20) begin
         @(negedge i_clk);
         k++;
      end
      chk(tag, o_mem_req, 1);
   endtask

   task automatic ack_after(input int n, input logic [XLEN-1:0] data);
      repeat (n) @(negedge i_clk);
      i_mem_ack   = 1'b1;
      i_mem_rdata = data;
      @(negedge i_clk);
      i_mem_ack   = 1'b0;
      i_mem_rdata = '0;
   endtask

   task automatic do_reset();
      i_rst = 1'b0;
      repeat (3) @(negedge i_clk);
      i_rst = 1'b1;
      @(negedge i_clk);
   endtask

   initial begin
      int cnt;
      repeat (3) @(negedge i_clk);
      chk("rst_mem_req", o_mem_req, 0);
      chk("rst_mem_addr", o_mem_addr, 0);
      chk("rst_ic_ready", o_ic_ready, 0);
      chk("rst_dm_ready", o_dm_ready, 0);
      chk("rst_ic_rdata", o_ic_rdata, 0);
      chk("rst_dm_err", o_dm_err, 0);
      i_rst = 1'b1;
      @(negedge i_clk);

      // IC refill, two wait states.
      i_ic_req = 1'b1; i_ic_addr = 32'h0000_0100;
      wait_req("ic_req_seen");
      chk("ic_addr", o_mem_addr, 32'h0000_0100);
      chk("ic_we", o_mem_we, 0);
      chk("ic_f3", o_mem_f3, 3'b010);
      ack_after(2, 32'hDEAD_BEEF);
      chk("ic_ready_pulse", o_ic_ready, 1);
      chk("ic_rdata_lit", o_ic_rdata, 32'hDEAD_BEEF);
      chk("ic_err_lit", o_ic_err, 0);
      i_ic_req = 1'b0;
      @(negedge i_clk);
      chk("ic_ready_drop", o_ic_ready, 0);

      // DM store, zero wait states.
      i_dm_wr = 1'b1; i_dm_addr = 32'h8000_0004; i_dm_wd = 32'h1234_5678; i_dm_f3 = 3'b001;
      wait_req("st_req_seen");
      chk("st_we", o_mem_we, 1);
      chk("st_addr", o_mem_addr, 32'h8000_0004);
      chk("st_wd", o_mem_wd, 32'h1234_5678);
      chk("st_f3", o_mem_f3, 3'b001);
      ack_after(0, 32'hFFFF_FFFF);
      chk("st_ready", o_dm_ready, 1);
      chk("st_rdata_zero", o_dm_rdata, 0);
      i_dm_wr = 1'b0;

      // Tie after reset: strict alternation starting with IC.
      do_reset();
      i_ic_req = 1'b1; i_ic_addr = 32'h0000_0300;
      i_dm_rd  = 1'b1; i_dm_addr = 32'h0000_0400; i_dm_f3 = 3'b010;
      for (int i = 0; i < 4; i++) begin
         wait_req("tie_req_seen");
         chk("tie_owner_addr", o_mem_addr, (i % 2 == 0) ? 32'h0000_0300 : 32'h0000_0400);
         ack_after(1, 32'h0000_1000 + i);
         chk("tie_ic_ready", o_ic_ready, (i % 2 == 0) ? 1 : 0);
         chk("tie_dm_ready", o_dm_ready, (i % 2 == 0) ? 0 : 1);
      end
      i_ic_req = 1'b0; i_dm_rd = 1'b0;
      @(negedge i_clk);

      // Never-acked DM read times out after TIMEOUT request cycles.
      i_dm_rd = 1'b1; i_dm_addr = 32'h0000_0500;
      wait_req("to_req_seen");
      cnt = 0;
      while (o_mem_req === 1'b1 && cnt < 50) begin
         cnt++;
         @(negedge i_clk);
      end
      chk("to_req_cycles", cnt, 8);
      chk("to_ready", o_dm_ready, 1);
      chk("to_err", o_dm_err, 1);
      chk("to_rdata", o_dm_rdata, 0);
      i_dm_rd = 1'b0;
      @(negedge i_clk);

      // Ack in the expiry cycle wins over the timeout.
      i_dm_rd = 1'b1;
      wait_req("edge_req_seen");
      ack_after(7, 32'h55AA_0001);
      chk("edge_ready", o_dm_ready, 1);
      chk("edge_err", o_dm_err, 0);
      chk("edge_rdata", o_dm_rdata, 32'h55AA_0001);
      i_dm_rd = 1'b0;
      @(negedge i_clk);

      // Read and write strobes together are a write.
      i_dm_rd = 1'b1; i_dm_wr = 1'b1; i_dm_addr = 32'h0000_0600;
      i_dm_wd = 32'h0000_CAFE; i_dm_f3 = 3'b000;
      wait_req("rw_req_seen");
      chk("rw_we", o_mem_we, 1);
      chk("rw_wd", o_mem_wd, 32'h0000_CAFE);
      ack_after(0, 32'h0000_FFFF);
      chk("rw_ready", o_dm_ready, 1);
      chk("rw_rdata_zero", o_dm_rdata, 0);
      i_dm_rd = 1'b0; i_dm_wr = 1'b0;
      @(negedge i_clk);

      // Reset while a transaction is outstanding; a stray ack is ignored.
      i_ic_req = 1'b1; i_ic_addr = 32'h0000_0200;
      wait_req("mid_req_seen");
      i_rst = 1'b0;
      @(negedge i_clk);
      chk("mid_rst_req", o_mem_req, 0);
      chk("mid_rst_addr", o_mem_addr, 0);
      chk("mid_rst_we", o_mem_we, 0);
      chk("mid_rst_ic_rdata", o_ic_rdata, 0);
      i_rst = 1'b1; i_ic_req = 1'b0;
      i_mem_ack = 1'b1; i_mem_rdata = 32'hBAD0_BAD0;
      @(negedge i_clk);
      i_mem_ack = 1'b0; i_mem_rdata = '0;
      for (int i = 0; i < 3; i++) begin
         chk("stray_ic_ready", o_ic_ready, 0);
         chk("stray_dm_ready", o_dm_ready, 0);
         @(negedge i_clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
